multicycle_controller: RTL and testbench

- FSM that sequences the RV32I datapath over several cycles per instruction, replacing the flat single-cycle decode.
- Sits between the PC/IR registers, register file, ALU and a variable-latency instruction/data memory.
- Produces per-state enables, the 4-bit ALU operation and a retired-instruction count.
- Traps on an illegal opcode or a memory timeout.

---
 rtl/multicycle_controller_pkg.sv | 41 ++++
 rtl/multicycle_controller_alu_op_decode.sv | 71 +++++++
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } aluOperations;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } ctrl_state_t;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_IMEM    = 2'b10;
   localparam logic [1:0] FAULT_DMEM    = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_op_decode.sv
// Combinational decode of opcode/funct fields into ALU operation, operand
// select and an opcode-legality flag.
module alu_op_decode
   import multicycle_controller_pkg::*;
(
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic [6:0]   funct7,
   output aluOperations alu_op,
   output logic         alu_src,
   output logic         legal
);

   logic f7_zero;
   logic f7_alt;

   assign f7_zero = (funct7 == 7'b0000000);
   assign f7_alt  = (funct7 == 7'b0100000);

   // Per-opcode ALU selection; anything not explicitly listed falls back to ADD.
   always_comb begin
      alu_op  = ALU_ADD;
      alu_src = 1'b0;
      legal   = 1'b1;
      case (opcode)
         OPC_R: begin
            case (funct3)
               3'b000: if (f7_alt) alu_op = ALU_SUB;
               3'b001: if (f7_zero) alu_op = ALU_SLL;
               3'b010: if (f7_zero) alu_op = ALU_SLT;
               3'b011: if (f7_zero) alu_op = ALU_SLTU;
               3'b100: if (f7_zero) alu_op = ALU_XOR;
               3'b101: begin
                  if (f7_zero)     alu_op = ALU_SRL;
                  else if (f7_alt) alu_op = ALU_SRA;
               end
               3'b110: if (f7_zero) alu_op = ALU_OR;
               3'b111: if (f7_zero) alu_op = ALU_AND;
               default: alu_op = ALU_ADD;
            endcase
         end
         OPC_I: begin
            alu_src = 1'b1;
            case (funct3)
               3'b000: alu_op = ALU_ADD;
               3'b001: if (f7_zero) alu_op = ALU_SLL;
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b100: alu_op = ALU_XOR;
               3'b101: begin
                  if (f7_zero)     alu_op = ALU_SRL;
                  else if (f7_alt) alu_op = ALU_SRA;
               end
               3'b110: alu_op = ALU_OR;
               3'b111: alu_op = ALU_AND;
               default: alu_op = ALU_ADD;
            endcase
         end
         OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
            alu_src = 1'b1;
         end
         OPC_BRANCH: begin
            alu_op = ALU_SUB;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait
// timeouts, sticky trap state and a retired-instruction counter.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             irWrite,
   output logic             pcWrite,
   output logic             regWrite,
   output logic             memWrite,
   output logic             aluSrc,
   output logic             branEnable,
   output logic             jumpEnable,
   output aluOperations     aluOp,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] instret
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   ctrl_state_t      state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [1:0]       fault_code_q, fault_code_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             retire;

   aluOperations     dec_op;
   logic             dec_src;
   logic             dec_legal;

   logic             is_load, is_store, is_branch, is_jump;

   alu_op_decode u_alu_op_decode (
      .opcode  (opcode),
      .funct3  (funct3),
      .funct7  (funct7),
      .alu_op  (dec_op),
      .alu_src (dec_src),
      .legal   (dec_legal)
   );

   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

   assign fault      = (state_q == TRAP);
   assign fault_code = fault_code_q;
   assign instret    = instret_q;

   // State, wait counter, fault code and retire counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         wait_cnt_q   <= '0;
         fault_code_q <= FAULT_NONE;
         instret_q    <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         fault_code_q <= fault_code_d;
         instret_q    <= instret_d;
      end
   end

   // Next-state, wait-count and per-state strobe decode.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      fault_code_d = fault_code_q;
      instret_d    = instret_q;
      retire       = 1'b0;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      irWrite      = 1'b0;
      pcWrite      = 1'b0;
      regWrite     = 1'b0;
      memWrite     = 1'b0;
      aluSrc       = 1'b0;
      branEnable   = 1'b0;
      jumpEnable   = 1'b0;
      aluOp        = ALU_ADD;

      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               irWrite = 1'b1;
               state_d = DECODE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d      = TRAP;
               fault_code_d = FAULT_IMEM;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         DECODE: begin
            if (!dec_legal) begin
               state_d      = TRAP;
               fault_code_d = FAULT_ILLEGAL;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            aluOp  = dec_op;
            aluSrc = dec_src;
            if (is_branch) begin
               branEnable = 1'b1;
               pcWrite    = 1'b1;
               retire     = 1'b1;
               state_d    = FETCH;
            end else if (is_load || is_store) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            aluOp    = dec_op;
            aluSrc   = dec_src;
            dmem_req = 1'b1;
            memWrite = is_store;
            if (dmem_ready) begin
               if (is_store) begin
                  pcWrite = 1'b1;
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d      = TRAP;
               fault_code_d = FAULT_DMEM;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         WB: begin
            aluOp      = dec_op;
            aluSrc     = dec_src;
            regWrite   = 1'b1;
            pcWrite    = 1'b1;
            jumpEnable = is_jump;
            retire     = 1'b1;
            state_d    = FETCH;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      // Any state change restarts the wait count for the new state.
      if (state_d != state_q) wait_cnt_d = '0;

      if (retire) instret_d = instret_q + CNT_W'(1);

      // Reset suppresses every strobe combinationally in the cycle it is
      // sampled, so an aborted instruction never writes anything.
      if (rst) begin
         imem_req   = 1'b0;
         dmem_req   = 1'b0;
         irWrite    = 1'b0;
         pcWrite    = 1'b0;
         regWrite   = 1'b0;
         memWrite   = 1'b0;
         aluSrc     = 1'b0;
         branEnable = 1'b0;
         jumpEnable = 1'b0;
         aluOp      = ALU_ADD;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a transaction-level model
// expands each instruction into its expected per-cycle output trace.
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   localparam int unsigned TB_TIMEOUT = 4;
   localparam int unsigned TB_CNT_W   = 4;

   localparam logic [6:0] LEGAL_OPS [9] = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};

   logic                clk = 1'b0;
   logic                rst;
   logic [6:0]          opcode;
   logic [2:0]          funct3;
   logic [6:0]          funct7;
   logic                imem_ready, dmem_ready;
   logic                imem_req, dmem_req, irWrite, pcWrite, regWrite, memWrite;
   logic                aluSrc, branEnable, jumpEnable, fault;
   aluOperations        aluOp;
   logic [1:0]          fault_code;
   logic [TB_CNT_W-1:0] instret;

   multicycle_controller #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7     (funct7),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .irWrite    (irWrite),
      .pcWrite    (pcWrite),
      .regWrite   (regWrite),
      .memWrite   (memWrite),
      .aluSrc     (aluSrc),
      .branEnable (branEnable),
      .jumpEnable (jumpEnable),
      .aluOp      (aluOp),
      .fault      (fault),
      .fault_code (fault_code),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       imem_ready;
      logic       dmem_ready;
   } stim_t;

   typedef struct packed {
      logic       imem_req, dmem_req, irWrite, pcWrite, regWrite, memWrite;
      logic       aluSrc, branEnable, jumpEnable;
      logic [3:0] aluOp;
      logic       fault;
      logic [1:0] fault_code;
      logic [3:0] instret;
   } obs_t;

   typedef struct packed {
      stim_t s;
      obs_t  e;
   } cyc_t;

   cyc_t        plan[$];
   int          m_instret = 0;
   int unsigned trap_len  = 3;
   int          vectors   = 0;
   int          miscompares = 0;

   // ---------------- reference model ----------------
   function automatic bit ref_legal(input logic [6:0] opc);
      foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == opc) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7);
      aluOperations base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                 ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      bit is_shift = (f3 == 3'd1) || (f3 == 3'd5);
      if (opc == OPC_BRANCH) return ALU_SUB;
      if (opc != OPC_R && opc != OPC_I) return ALU_ADD;
      if (opc == OPC_I && !is_shift) return base[f3];
      if (f7 == 7'h00) return base[f3];
      if (f7 == 7'h20 && f3 == 3'd0 && opc == OPC_R) return ALU_SUB;
      if (f7 == 7'h20 && f3 == 3'd5) return ALU_SRA;
      return ALU_ADD;
   endfunction

   function automatic logic ref_src(input logic [6:0] opc);
      return (opc != OPC_R) && (opc != OPC_BRANCH);
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst        = 1'b0;
      s.opc        = 7'($urandom);
      s.f3         = 3'($urandom);
      s.f7         = 7'($urandom);
      s.imem_ready = 1'($urandom);
      s.dmem_ready = 1'($urandom);
      return s;
   endfunction

   function automatic stim_t instr_stim(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7);
      stim_t s = rand_stim();
      s.opc = opc;
      s.f3  = f3;
      s.f7  = f7;
      return s;
   endfunction

   function automatic obs_t idle_obs();
      obs_t o = '0;
      o.aluOp   = ALU_ADD;
      o.instret = 4'(m_instret);
      return o;
   endfunction

   function automatic void push(input stim_t s, input obs_t o);
      cyc_t c;
      c.s = s;
      c.e = o;
      plan.push_back(c);
   endfunction

   function automatic void retire();
      m_instret = (m_instret + 1) % (1 << TB_CNT_W);
   endfunction

   // Trap: strobes silent, fault visible, then a one-cycle reset.
   function automatic void model_trap(input logic [1:0] code);
      stim_t s;
      obs_t  o;
      for (int unsigned n = 0; n < trap_len; n++) begin
         s = rand_stim();
         o = idle_obs();
         o.fault = 1'b1;
         o.fault_code = code;
         push(s, o);
      end
      s = rand_stim();
      s.rst = 1'b1;
      o = idle_obs();
      o.fault = 1'b1;
      o.fault_code = code;
      push(s, o);
      m_instret = 0;
   endfunction

   // Expand one instruction into its expected cycle trace.
   function automatic void model_instr(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7, input int unsigned iw,
                                       input int unsigned dw);
      stim_t s;
      obs_t  o;
      bit    is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
      bit    is_st  = (opc == OPC_STORE);
      for (int unsigned k = 0; k < iw && k < TB_TIMEOUT; k++) begin
         s = rand_stim(); s.imem_ready = 1'b0;
         o = idle_obs();  o.imem_req = 1'b1;
         push(s, o);
      end
      if (iw >= TB_TIMEOUT) begin
         model_trap(FAULT_IMEM);
         return;
      end
      s = rand_stim(); s.imem_ready = 1'b1;
      o = idle_obs();  o.imem_req = 1'b1; o.irWrite = 1'b1;
      push(s, o);
      push(instr_stim(opc, f3, f7), idle_obs());
      if (!ref_legal(opc)) begin
         model_trap(FAULT_ILLEGAL);
         return;
      end
      o = idle_obs();
      o.aluOp  = ref_alu(opc, f3, f7);
      o.aluSrc = ref_src(opc);
      if (opc == OPC_BRANCH) begin
         o.branEnable = 1'b1;
         o.pcWrite    = 1'b1;
         push(instr_stim(opc, f3, f7), o);
         retire();
         return;
      end
      push(instr_stim(opc, f3, f7), o);
      if (is_mem) begin
         for (int unsigned k = 0; k < dw && k < TB_TIMEOUT; k++) begin
            s = instr_stim(opc, f3, f7); s.dmem_ready = 1'b0;
            o = idle_obs();
            o.aluOp = ref_alu(opc, f3, f7); o.aluSrc = ref_src(opc);
            o.dmem_req = 1'b1; o.memWrite = is_st;
            push(s, o);
         end
         if (dw >= TB_TIMEOUT) begin
            model_trap(FAULT_DMEM);
            return;
         end
         s = instr_stim(opc, f3, f7); s.dmem_ready = 1'b1;
         o = idle_obs();
         o.aluOp = ref_alu(opc, f3, f7); o.aluSrc = ref_src(opc);
         o.dmem_req = 1'b1; o.memWrite = is_st;
         if (is_st) begin
            o.pcWrite = 1'b1;
            push(s, o);
            retire();
            return;
         end
         push(s, o);
      end
      o = idle_obs();
      o.aluOp = ref_alu(opc, f3, f7); o.aluSrc = ref_src(opc);
      o.regWrite = 1'b1; o.pcWrite = 1'b1;
      o.jumpEnable = (opc == OPC_JAL) || (opc == OPC_JALR);
      push(instr_stim(opc, f3, f7), o);
      retire();
   endfunction

   // ---------------- DUT access ----------------
   task automatic drive(input stim_t s);
      rst        = s.rst;
      opcode     = s.opc;
      funct3     = s.f3;
      funct7     = s.f7;
      imem_ready = s.imem_ready;
      dmem_ready = s.dmem_ready;
   endtask

   function automatic obs_t observe();
      obs_t o;
      o.imem_req = imem_req;   o.dmem_req = dmem_req;   o.irWrite = irWrite;
      o.pcWrite = pcWrite;     o.regWrite = regWrite;   o.memWrite = memWrite;
      o.aluSrc = aluSrc;       o.branEnable = branEnable; o.jumpEnable = jumpEnable;
      o.aluOp = aluOp;         o.fault = fault;         o.fault_code = fault_code;
      o.instret = instret;
      return o;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      obs_t exp_o = '0;
      drive(rand_stim());
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (observe() !== exp_o) begin
         miscompares++;
         $display("FAIL reset_outputs: dut=%h model=%h", observe(), exp_o);
      end
      @(posedge clk); #1;
      m_instret = 0;
   endtask

   task automatic test_alu_add();
      plan.delete();
      model_instr(OPC_R, 3'b000, 7'b0000000, 0, 0);
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL add cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         @(posedge clk); #1;
      end
      vectors++;
      if (instret !== 4'(m_instret)) begin
         miscompares++;
         $display("FAIL add_instret: dut=%0d model=%0d", instret, m_instret);
      end
   endtask

   task automatic test_load_wait();
      int dreq_cnt = 0, mw_cnt = 0, rw_idx = -1;
      plan.delete();
      model_instr(OPC_LOAD, 3'b010, 7'h00, 0, 3);
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL load cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         dreq_cnt += int'(dmem_req);
         mw_cnt   += int'(memWrite);
         if (regWrite && rw_idx < 0) rw_idx = i;
         @(posedge clk); #1;
      end
      vectors++;
      if (dreq_cnt != 4 || mw_cnt != 0 || rw_idx != 7) begin
         miscompares++;
         $display("FAIL load_timing: dmem_req=%0d memWrite=%0d wb_cycle=%0d want 4/0/7",
                  dreq_cnt, mw_cnt, rw_idx);
      end
   endtask

   task automatic test_store_branch();
      int mw_cnt = 0, rw_cnt = 0, be_cnt = 0;
      int base = m_instret;
      plan.delete();
      model_instr(OPC_STORE, 3'b010, 7'h00, 0, 0);
      model_instr(OPC_BRANCH, 3'b000, 7'h00, 0, 0);
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL store_branch cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         mw_cnt += int'(memWrite);
         rw_cnt += int'(regWrite);
         be_cnt += int'(branEnable);
         @(posedge clk); #1;
      end
      vectors++;
      if (mw_cnt != 1 || rw_cnt != 0 || be_cnt != 1 || instret !== 4'(base + 2)) begin
         miscompares++;
         $display("FAIL store_branch_summary: memWrite=%0d regWrite=%0d branEnable=%0d instret=%0d want 1/0/1/%0d",
                  mw_cnt, rw_cnt, be_cnt, instret, (base + 2) % 16);
      end
   endtask

   task automatic test_jalr();
      plan.delete();
      model_instr(OPC_JALR, 3'b000, 7'h00, 0, 0);
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL jalr cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         if (i == 3) begin
            vectors++;
            if (!(regWrite && jumpEnable && pcWrite && aluSrc) || aluOp !== ALU_ADD) begin
               miscompares++;
               $display("FAIL jalr_wb: rw=%b je=%b pw=%b src=%b op=%0d want 1/1/1/1/0",
                        regWrite, jumpEnable, pcWrite, aluSrc, aluOp);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      int strobe_hits = 0;
      plan.delete();
      trap_len = 20;
      model_instr(7'b1111111, 3'b000, 7'h00, 0, 0);
      trap_len = 3;
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL illegal cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         if (fault && (imem_req | dmem_req | irWrite | pcWrite | regWrite | memWrite))
            strobe_hits++;
         @(posedge clk); #1;
      end
      vectors++;
      if (strobe_hits != 0 || fault !== 1'b0 || fault_code !== 2'b00 || instret !== '0) begin
         miscompares++;
         $display("FAIL illegal_recover: strobes_in_trap=%0d fault=%b code=%b instret=%0d want 0/0/00/0",
                  strobe_hits, fault, fault_code, instret);
      end
   endtask

   task automatic test_imem_timeout();
      int req_before_fault = 0, first_code = -1;
      plan.delete();
      model_instr(OPC_R, 3'b000, 7'h00, TB_TIMEOUT, 0);
      model_instr(OPC_I, 3'b101, 7'h20, TB_TIMEOUT - 1, 0);
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL imem_timeout cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         if (fault && first_code < 0) first_code = int'(fault_code);
         if (first_code < 0) req_before_fault += int'(imem_req);
         @(posedge clk); #1;
      end
      vectors++;
      if (req_before_fault != TB_TIMEOUT || first_code != 2) begin
         miscompares++;
         $display("FAIL imem_timeout_count: fetch_cycles=%0d code=%0d want %0d/2",
                  req_before_fault, first_code, TB_TIMEOUT);
      end
   endtask

   task automatic test_back_to_back();
      plan.delete();
      for (int n = 0; n < 18; n++)
         model_instr(LEGAL_OPS[$urandom_range(0, 8)], 3'($urandom), 7'($urandom_range(0, 1) * 32), 0, 0);
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL back_to_back cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [6:0]  opc;
      logic [6:0]  f7;
      int unsigned start, cut;
      cyc_t        c;
      plan.delete();
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do opc = 7'($urandom); while (ref_legal(opc));
         end else begin
            opc = LEGAL_OPS[$urandom_range(0, 8)];
         end
         case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         trap_len = $urandom_range(1, 4);
         start = plan.size();
         model_instr(opc, 3'($urandom), f7,
                     ($urandom_range(0, 7) == 0) ? TB_TIMEOUT : $urandom_range(0, TB_TIMEOUT - 1),
                     ($urandom_range(0, 7) == 0) ? TB_TIMEOUT : $urandom_range(0, TB_TIMEOUT - 1));
         if ($urandom_range(0, 9) == 0) begin
            // abort mid-instruction: same visible state, strobes silenced
            cut = start + $urandom_range(0, plan.size() - start - 1);
            c = plan[cut];
            c.s.rst = 1'b1;
            c.e.imem_req = 0; c.e.dmem_req = 0; c.e.irWrite = 0; c.e.pcWrite = 0;
            c.e.regWrite = 0; c.e.memWrite = 0; c.e.aluSrc = 0; c.e.branEnable = 0;
            c.e.jumpEnable = 0; c.e.aluOp = ALU_ADD;
            while (plan.size() > cut) void'(plan.pop_back());
            plan.push_back(c);
            m_instret = 0;
         end
      end
      trap_len = 3;
      foreach (plan[i]) begin
         drive(plan[i].s);
         @(negedge clk);
         vectors++;
         if (observe() !== plan[i].e) begin
            miscompares++;
            $display("FAIL random cycle %0d: dut=%h model=%h", i, observe(), plan[i].e);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_alu_add();
      test_load_wait();
      test_store_branch();
      test_jalr();
      test_illegal();
      test_imem_timeout();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
